// File: rtl/rob_rollback.sv
// rob_rollback: N-way reorder buffer with single-cycle tail rollback.
// Dispatch writes up to N entries per cycle at the tail. Retire frees up to
// N entries per cycle from the head. A squash discards every entry from
// squash_idx onward, and squash_idx becomes the new tail.
// Optional build macro ROB_DEBUG_EN adds the ports dbg_head, dbg_count and
// dbg_overflow.
module rob_rollback #(
   parameter int DEPTH  = 32,
   parameter int N      = 3,
   parameter int DATA_W = 32,
   localparam int IDX_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int NW    = $clog2(N + 1)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [N-1:0][DATA_W-1:0]   in_data,
   input  logic [NW-1:0]              in_count,
   input  logic [NW-1:0]              retire_count,
   input  logic                       squash_valid,
   input  logic [IDX_W-1:0]           squash_idx,
   output logic [N-1:0][DATA_W-1:0]   out_data,
   output logic [NW-1:0]              out_count,
   output logic [NW-1:0]              spots,
   output logic [IDX_W-1:0]           tail
`ifdef ROB_DEBUG_EN
   ,
   output logic [IDX_W-1:0]           dbg_head,
   output logic [CNT_W-1:0]           dbg_count,
   output logic                       dbg_overflow
`endif
);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] N_C     = CNT_W'(N);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [IDX_W-1:0]  head_q, head_d;
   logic [IDX_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [CNT_W-1:0]  ret_ext;
   logic [CNT_W-1:0]  in_ext;
   logic [CNT_W-1:0]  ret_norm;
   logic [CNT_W-1:0]  free_slots;
   logic [CNT_W-1:0]  disp_k;
   logic [IDX_W-1:0]  live_idx;
   logic [CNT_W-1:0]  live;
   logic [CNT_W-1:0]  ret_sq;
   logic [CNT_W-1:0]  room;

   // Clamp the requested retire and dispatch counts.
   // Dispatch may reuse entries that are freed in the same cycle.
   always_comb begin
      ret_ext    = CNT_W'(retire_count);
      in_ext     = CNT_W'(in_count);
      ret_norm   = (ret_ext > count_q) ? count_q : ret_ext;
      free_slots = DEPTH_C - count_q + ret_norm;
      disp_k     = (in_ext > free_slots) ? free_slots : in_ext;
   end

   // Work out how many entries survive a squash. A squash to the head of a
   // full buffer gives a zero difference mod DEPTH, so it reads as a full
   // flush and not as "keep everything".
   always_comb begin
      live_idx = squash_idx - head_q;
      live     = CNT_W'(live_idx);
      if ((count_q == DEPTH_C) && (squash_idx == head_q)) begin
         live = '0;
      end
      ret_sq = (ret_ext > live) ? live : ret_ext;
   end

   // Next-state logic: a squash rolls back the tail, otherwise dispatch and
   // retire proceed together.
   always_comb begin
      logic [IDX_W-1:0] wr_idx;
      wr_idx  = '0;
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (squash_valid) begin
         head_d  = head_q + IDX_W'(ret_sq);
         tail_d  = squash_idx;
         count_d = live - ret_sq;
      end else begin
         head_d  = head_q + IDX_W'(ret_norm);
         tail_d  = tail_q + IDX_W'(disp_k);
         count_d = count_q - ret_norm + disp_k;
         for (int i = 0; i < N; i++) begin
            wr_idx = tail_q + IDX_W'(i);
            if (CNT_W'(i) < disp_k) begin
               mem_d[wr_idx] = in_data[i];
            end
         end
      end
   end

   // State registers. Reset clears the storage and overrides any squash,
   // dispatch or retire in the same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         mem_q   <= mem_d;
      end
   end

   // Outputs come from registered state only.
   // The read window wraps around index DEPTH-1 back to 0.
   always_comb begin
      logic [IDX_W-1:0] rd_idx;
      rd_idx = '0;
      for (int i = 0; i < N; i++) begin
         rd_idx      = head_q + IDX_W'(i);
         out_data[i] = mem_q[rd_idx];
      end
      room      = DEPTH_C - count_q;
      out_count = (count_q > N_C) ? NW'(N) : NW'(count_q);
      spots     = (room > N_C) ? NW'(N) : NW'(room);
      tail      = tail_q;
   end

`ifdef ROB_DEBUG_EN
   logic dbg_overflow_q, dbg_overflow_d;

   // Flag any clamped request. The flag appears for one cycle after the
   // edge that applied the clamp.
   always_comb begin
      dbg_overflow_d = 1'b0;
      if (squash_valid) begin
         dbg_overflow_d = (ret_ext > live);
      end else begin
         dbg_overflow_d = (ret_ext > count_q) || (in_ext > free_slots);
      end
   end

   // Debug flag register.
   always_ff @(posedge clock) begin
      if (reset) begin
         dbg_overflow_q <= 1'b0;
      end else begin
         dbg_overflow_q <= dbg_overflow_d;
      end
   end

   // Debug visibility of the internal head pointer and occupancy.
   always_comb begin
      dbg_head     = head_q;
      dbg_count    = count_q;
      dbg_overflow = dbg_overflow_q;
   end
`endif

endmodule

// File: tb/tb_rob_rollback.sv
// tb_rob_rollback: directed test of rob_rollback with DEPTH=8 and N=3.
// Each payload is its sequence number. Expected values were worked out by
// hand from the buffer's head/tail/count behaviour.
module tb_rob_rollback;

   localparam int DEPTH  = 8;
   localparam int N      = 3;
   localparam int DATA_W = 32;
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int NW     = $clog2(N + 1);

   logic                     clock;
   logic                     reset;
   logic [N-1:0][DATA_W-1:0] inData;
   logic [NW-1:0]            inCount;
   logic [NW-1:0]            retireCount;
   logic                     squashValid;
   logic [IDX_W-1:0]         squashIdx;
   logic [N-1:0][DATA_W-1:0] outData;
   logic [NW-1:0]            outCount;
   logic [NW-1:0]            spots;
   logic [IDX_W-1:0]         tail;
`ifdef ROB_DEBUG_EN
   logic [IDX_W-1:0]         dbgHead;
   logic [CNT_W-1:0]         dbgCount;
   logic                     dbgOverflow;
`endif

   int testCount = 0;
   int failCount = 0;

   rob_rollback #(
      .DEPTH (DEPTH),
      .N     (N),
      .DATA_W(DATA_W)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .in_data     (inData),
      .in_count    (inCount),
      .retire_count(retireCount),
      .squash_valid(squashValid),
      .squash_idx  (squashIdx),
      .out_data    (outData),
      .out_count   (outCount),
      .spots       (spots),
      .tail        (tail)
`ifdef ROB_DEBUG_EN
      ,
      .dbg_head    (dbgHead),
      .dbg_count   (dbgCount),
      .dbg_overflow(dbgOverflow)
`endif
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Drive one cycle of inputs, let the edge apply them, then return to idle.
   task automatic applyStimulus(input logic rst, input int cnt, input int d0, input int d1,
                                input int d2, input int ret, input logic sqv, input int sqi);
      reset       = rst;
      inCount     = NW'(cnt);
      inData[0]   = DATA_W'(d0);
      inData[1]   = DATA_W'(d1);
      inData[2]   = DATA_W'(d2);
      retireCount = NW'(ret);
      squashValid = sqv;
      squashIdx   = IDX_W'(sqi);
      @(posedge clock);
      #1;
      reset       = 1'b0;
      inCount     = '0;
      inData      = '0;
      retireCount = '0;
      squashValid = 1'b0;
      squashIdx   = '0;
   endtask

   // One immediate-assertion comparison.
   task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Compare the visible outputs against hand-computed values.
   // Only the first nData slots of out_data are checked.
   task automatic checkOutput(input string tag, input int expCount, input int expSpots, input int expTail,
                              input int nData, input int d0, input int d1, input int d2);
      int expData [3];
      expData[0] = d0;
      expData[1] = d1;
      expData[2] = d2;
      checkVal($sformatf("%s.out_count", tag), 32'(outCount), 32'(expCount));
      checkVal($sformatf("%s.spots", tag), 32'(spots), 32'(expSpots));
      checkVal($sformatf("%s.tail", tag), 32'(tail), 32'(expTail));
      for (int i = 0; i < nData; i++) begin
         checkVal($sformatf("%s.out_data[%0d]", tag, i), outData[i], 32'(expData[i]));
      end
   endtask

   // Directed sequence.
   initial begin
      reset       = 1'b1;
      inCount     = '0;
      inData      = '0;
      retireCount = '0;
      squashValid = 1'b0;
      squashIdx   = '0;

      // Reset state
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("reset", 0, 3, 0, 3, 0, 0, 0);

      // Fill: 3 per cycle, last write clamped to 2
      applyStimulus(0, 3, 0, 1, 2, 0, 0, 0);
      checkOutput("fill1", 3, 3, 3, 3, 0, 1, 2);
      applyStimulus(0, 3, 3, 4, 5, 0, 0, 0);
      checkOutput("fill2", 3, 2, 6, 3, 0, 1, 2);
      applyStimulus(0, 3, 6, 7, 8, 0, 0, 0);
      checkOutput("fillFull", 3, 0, 0, 3, 0, 1, 2);

      // Full buffer: retire 3 and dispatch 3 in the same cycle
      applyStimulus(0, 3, 8, 9, 10, 3, 0, 0);
      checkOutput("fullRetDisp", 3, 0, 3, 3, 3, 4, 5);

      // Move head and tail to 4 while the buffer stays full
      applyStimulus(0, 1, 11, 0, 0, 1, 0, 0);
      checkOutput("fullAt4", 3, 0, 4, 3, 4, 5, 6);

      // Full flush: squash to head == tail
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 4);
      checkOutput("fullFlush", 0, 3, 4, 0, 0, 0, 0);
      applyStimulus(0, 3, 20, 21, 22, 0, 0, 0);
      checkOutput("afterFlush", 3, 3, 7, 3, 20, 21, 22);

      // Wrap read: head 6, count 4
      applyStimulus(0, 3, 23, 24, 25, 0, 0, 0);
      checkOutput("wrapWrite", 3, 2, 2, 3, 20, 21, 22);
      applyStimulus(0, 0, 0, 0, 0, 2, 0, 0);
      checkOutput("wrapRead", 3, 3, 2, 3, 22, 23, 24);

      // Squash with retire: fill 0..5, squash to 2, retire 1
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 3, 0, 1, 2, 0, 0, 0);
      applyStimulus(0, 3, 3, 4, 5, 0, 0, 0);
      checkOutput("sqFill", 3, 2, 6, 3, 0, 1, 2);
      applyStimulus(0, 3, 99, 98, 97, 1, 1, 2);
      checkOutput("squash", 1, 3, 2, 1, 1, 0, 0);
      applyStimulus(0, 1, 50, 0, 0, 0, 0, 0);
      checkOutput("postSquash", 2, 3, 3, 2, 1, 50, 0);

      // Over-retire is clamped to count
      applyStimulus(0, 0, 0, 0, 0, 3, 0, 0);
      checkOutput("retClamp", 0, 3, 3, 0, 0, 0, 0);

      // Reset asserted during a squash cycle
      applyStimulus(0, 3, 60, 61, 62, 0, 0, 0);
      checkOutput("preReset", 3, 3, 6, 3, 60, 61, 62);
      applyStimulus(1, 3, 70, 71, 72, 1, 1, 4);
      checkOutput("resetSquash", 0, 3, 0, 3, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
